sha256_msg_sched: RTL

Message schedule stage directly upstream of the SHA-256 round/compression engine.
- Accepts one 512-bit padded message block through a valid/ready handshake.
- Streams the 64 schedule words W[0..63], one per accepted beat, on a 32-bit output with a round index and a last flag.
- Uses a 16-word sliding window. It never stores all 64 words.

---
 rtl/sha256_msg_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched
//
// SHA-256 message schedule stage. It accepts one 512-bit padded block over a
// valid/ready handshake and streams the schedule words W[0..ROUNDS-1] to the
// round engine, one word per accepted beat. Only a 16-word sliding window is
// kept. Each beat shifts the window down by one word and appends the next
// expanded word.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. valid does not wait for ready. Once valid is
// raised, the payload holds until the transfer happens.
//
// Ports:
//   clk        in   1    rising-edge clock
//   reset      in   1    synchronous, active-high reset
//   blk_valid  in   1    block present on blk_data
//   blk_ready  out  1    stage can accept a block
//   blk_data   in   512  padded block, [511:480] = W[0] ... [31:0] = W[15]
//   w_valid    out  1    W / w_idx / w_last valid
//   w_ready    in   1    consumer takes W this cycle
//   W          out  32   schedule word W[w_idx]
//   w_idx      out  6    round index t
//   w_last     out  1    high when w_idx == ROUNDS-1
//   dbg_state  out  1    FSM state (0 = IDLE, 1 = RUN)
//
// Optional build macro: SHA256_SCHED_PRELOAD_EN
//   When defined, the next block can be accepted on the final beat of the
//   current block. This removes the one-cycle bubble between blocks.
// -----------------------------------------------------------------------------
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  W,
    output logic [5:0]   w_idx,
    output logic         w_last,
    output logic         dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  t_q, t_d;
    logic        last_q, last_d;

    logic        beat;
    logic        load;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        last_d  = last_q;

        beat = (state_q == RUN) && w_ready;

`ifdef SHA256_SCHED_PRELOAD_EN
        // The final beat frees the window, so a new block can load over it
        // in the same cycle.
        blk_ready = (state_q == IDLE) || ((state_q == RUN) && last_q && w_ready);
`else
        blk_ready = (state_q == IDLE);
`endif

        load = blk_valid && blk_ready;

        if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = blk_data[511 - 32*i -: 32];
            end
            t_d     = 6'd0;
            last_d  = 1'b0;
            state_d = RUN;
        end else if (beat) begin
            if (last_q) begin
                t_d     = 6'd0;
                last_d  = 1'b0;
                state_d = IDLE;
            end else begin
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i+1];
                end
                // Once win_q[0] holds W[t], win_q[15] becomes W[t+16].
                win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
                t_d       = t_q + 6'd1;
                last_d    = ((t_q + 6'd1) == LAST_IDX);
            end
        end

        w_valid   = (state_q == RUN);
        W         = win_q[0];
        w_idx     = t_q;
        w_last    = last_q;
        dbg_state = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            last_q  <= last_d;
        end
        // The window has no reset. It is always loaded before use.
        win_q <= win_d;
    end

endmodule
